spike_event_queue: RTL and testbench
====================================

SPIKE_EVENT_QUEUE -- requirements
Module: spike_event_queue

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4, number of neuron_core instances served (2..16).
REQ-002 SHALL have parameter DEPTH, default 8, event FIFO entries (power of two, 2..64).
REQ-003 SHALL have parameter CORE_ID, default 8'h00, value placed in packet field [15:8].
REQ-004 SHALL have port clk, input, 1, sole clock; rising edge active.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port spike_detected, input, NUM_NEURONS, bit i is the spike flag from neuron core i.
REQ-007 SHALL have port spike_resolved, output, NUM_NEURONS, bit i is the one-cycle acknowledge to neuron core i.
REQ-008 SHALL have port time_step, input, 1, one-cycle pulse that advances the timestamp.
REQ-009 SHALL have port pkt_valid, output, 1, head packet is available.
REQ-010 SHALL have port pkt_ready, input, 1, consumer accepts the head packet.
REQ-011 SHALL have port pkt_data, output, 32, packet {timestamp[15:0], CORE_ID[7:0], neuron_index[7:0]}.
REQ-012 SHALL have port fifo_full, output, 1, FIFO occupancy equals DEPTH.
REQ-013 SHALL have port evt_count, output, 16, count of events pushed (see Configuration).

Function
REQ-014 SHALL hold a 16-bit timestamp counter that increments by 1 on each clock with time_step=1 and wraps from 16'hFFFF to 16'h0000.
REQ-015 SHALL keep per-neuron state IDLE/ACKED; neuron i is eligible only when spike_detected[i]=1 and its state is IDLE.
REQ-016 SHALL grant at most one eligible neuron per cycle, round-robin starting from the index after the last grant, and only when occupancy < DEPTH.
REQ-017 SHALL, on a grant to neuron i in cycle t, write {timestamp, CORE_ID, i} to the FIFO at the end of t, drive spike_resolved[i]=1 during cycle t+1 only, and move neuron i to ACKED.
REQ-018 SHALL capture the timestamp value present before any increment that occurs in the same cycle.
REQ-019 SHALL return neuron i from ACKED to IDLE on the first cycle spike_detected[i] is sampled 0; no second event while still 1.
REQ-020 SHALL withhold grants and all spike_resolved bits while full; pending spikes remain pending and nothing is dropped.
REQ-021 SHALL present the FIFO head on pkt_data with pkt_valid=1 whenever occupancy > 0; a pop occurs on a clock with pkt_valid and pkt_ready both 1.
REQ-022 SHALL not bypass: a pushed entry appears on pkt_valid no earlier than cycle t+1; a push and pop in the same cycle leaves occupancy unchanged.
REQ-023 SHALL not admit a push when full even if a pop occurs in the same cycle.
REQ-024 SHALL hold pkt_data stable while pkt_valid=1 and pkt_ready=0.
REQ-025 SHALL deliver packets in push order.

Reset
REQ-026 SHALL, on rst_n=0 at any time, asynchronously clear FIFO occupancy and pointers, timestamp, evt_count, round-robin pointer (next grant search starts at index 0), and all per-neuron states to IDLE.
REQ-027 SHALL drive pkt_valid=0, spike_resolved=0, fifo_full=0 and pkt_data=0 during and immediately after reset; in-flight events are discarded.

Configuration
REQ-028 SHALL, with SEQ_EVT_COUNT_EN defined, increment evt_count on every push, saturating at 16'hFFFF.
REQ-029 SHALL, without SEQ_EVT_COUNT_EN, omit the counter logic and tie evt_count to 16'h0000; all other behaviour is identical.

Verification
REQ-030 SHALL cover single spike: neuron 2 rises with timestamp=5 -> spike_resolved[2] one cycle, packet 32'h0005_0002, pkt_valid next cycle.
REQ-031 SHALL cover simultaneous spikes: neurons 0,1,3 rise together with the pointer after reset -> acks in cycles t+1, t+2, t+3 and packets in order 0,1,3.
REQ-032 SHALL cover held flag: spike_detected[1] held high 10 cycles -> exactly one packet and one ack.
REQ-033 SHALL cover full back-pressure: DEPTH=8, pkt_ready=0, nine spikes -> fifo_full=1 after 8 events, the ninth is not acked; after one pop, the ninth is acked and pushed.
REQ-034 SHALL cover wrap: timestamp at 16'hFFFF with time_step coincident with a grant -> packet carries FFFF and the counter becomes 0000.
REQ-035 SHALL cover mid-operation reset: reset with 3 queued events -> pkt_valid=0 and evt_count=0 after reset; with the macro, 20 pushes -> evt_count=20.

Source files
------------

// File: rtl/spike_event_queue.sv
// Spike event queue: round-robin arbiter over neuron-core spike flags that
// packs {timestamp, CORE_ID, neuron index} events into a FIFO for a
// valid/ready consumer.
// Optional feature: define SEQ_EVT_COUNT_EN to enable the saturating push
// counter on evt_count; otherwise evt_count is tied to zero.
module spike_event_queue #(
  parameter int          NUM_NEURONS = 4,
  parameter int          DEPTH       = 8,
  parameter logic [7:0]  CORE_ID     = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_NEURONS-1:0] spike_detected,
  output logic [NUM_NEURONS-1:0] spike_resolved,
  input  logic                   time_step,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic [31:0]            pkt_data,
  output logic                   fifo_full,
  output logic [15:0]            evt_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]            mem_q [DEPTH];
  logic [PW-1:0]          wr_q, rd_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [15:0]            ts_q;
  logic [NUM_NEURONS-1:0] acked_q, acked_d;
  logic [NUM_NEURONS-1:0] ack_q, ack_d;
  logic [4:0]             rr_q, rr_d;

  logic                   full, push, pop;
  logic                   grant_vld;
  logic [4:0]             grant_idx;
  logic [4:0]             idx;
  logic [31:0]            elig_w;
  logic [31:0]            pkt_new;

  // Eligibility padded to 32 bits so the 5-bit search index never runs off the end.
  assign elig_w  = 32'(spike_detected & ~acked_q);
  assign full    = (cnt_q == CW'(DEPTH));
  assign push    = grant_vld;
  assign pop     = (cnt_q != '0) && pkt_ready;
  assign pkt_new = {ts_q, CORE_ID, 3'b000, grant_idx};

  // Round-robin search for the first eligible neuron starting at rr_q; no grant while full.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    if (!full) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        idx = rr_q + 5'(k);
        if (idx >= 5'(NUM_NEURONS)) idx = idx - 5'(NUM_NEURONS);
        if (!grant_vld && elig_w[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx;
        end
      end
    end
  end

  // Next-state for occupancy, arbiter pointer, per-neuron ack state and the ack pulse.
  always_comb begin
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    rr_d    = rr_q;
    ack_d   = '0;
    if (grant_vld) begin
      rr_d  = (grant_idx == 5'(NUM_NEURONS - 1)) ? 5'd0 : grant_idx + 5'd1;
      ack_d = {{(NUM_NEURONS-1){1'b0}}, 1'b1} << grant_idx;
    end
    // A neuron stays ACKED while its flag is held and drops to IDLE once it is seen low.
    acked_d = (acked_q & spike_detected) | ack_d;
  end

  // Control state: pointers, occupancy, timestamp, arbiter and per-neuron state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ts_q    <= '0;
      rr_q    <= '0;
      acked_q <= '0;
      ack_q   <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      cnt_q   <= cnt_d;
      if (time_step) ts_q <= ts_q + 16'd1;
      rr_q    <= rr_d;
      acked_q <= acked_d;
      ack_q   <= ack_d;
    end
  end

  // Event storage; payload needs no reset because valid is qualified by occupancy.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= pkt_new;
  end

`ifdef SEQ_EVT_COUNT_EN
  logic [15:0] evt_q;

  // Saturating count of accepted events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else if (push && (evt_q != 16'hFFFF)) begin
      evt_q <= evt_q + 16'd1;
    end
  end

  assign evt_count = evt_q;
`else
  assign evt_count = 16'h0000;
`endif

  assign pkt_valid      = (cnt_q != '0);
  assign pkt_data       = pkt_valid ? mem_q[rd_q] : 32'h0;
  assign fifo_full      = full;
  assign spike_resolved = ack_q;

endmodule

// File: tb/tb_spike_event_queue.sv
// Directed bench for spike_event_queue with a packet scoreboard.
module tb_spike_event_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  spike_detected;
  logic [3:0]  spike_resolved;
  logic        time_step;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [31:0] pkt_data;
  logic        fifo_full;
  logic [15:0] evt_count;

  int          errors = 0;
  int          checks = 0;
  int          pops_n = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_pkt;
  logic [15:0] ts_m = 16'h0;

  spike_event_queue #(.NUM_NEURONS(4), .DEPTH(8), .CORE_ID(8'h00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .spike_detected (spike_detected),
    .spike_resolved (spike_resolved),
    .time_step      (time_step),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .pkt_data       (pkt_data),
    .fifo_full      (fifo_full),
    .evt_count      (evt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the reference timestamp follows time_step.
  task automatic tick();
    @(posedge clk);
    if (rst_n && time_step) ts_m = ts_m + 16'd1;
    #1;
  endtask

  task automatic drain();
    pkt_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: every accepted packet must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && pkt_valid && pkt_ready) begin
      checks++;
      pops_n++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL pkt_unexpected: observed=%h expected=none", pkt_data);
      end
      if (sb.size() != 0) begin
        exp_pkt = sb.pop_front();
        assert (pkt_data === exp_pkt) else begin
          errors++;
          $error("FAIL pkt_data: observed=%h expected=%h", pkt_data, exp_pkt);
        end
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int pops0;
    logic [15:0] evt_exp;

    rst_n = 1'b0; spike_detected = '0; time_step = 1'b0; pkt_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", pkt_valid, 1'b0);
    chk("rst_resolved", spike_resolved, 4'h0);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_data", pkt_data, 32'h0);
    chk("rst_evt", evt_count, 16'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", pkt_valid, 1'b0);

    // Single spike at timestamp 5
    pkt_ready = 1'b1;
    tick();
    time_step = 1'b1;
    repeat (5) tick();
    time_step = 1'b0;
    spike_detected = 4'b0100;
    sb.push_back(32'h0005_0002);
    @(negedge clk);
    chk("single_no_bypass", pkt_valid, 1'b0);
    chk("single_res_t", spike_resolved, 4'h0);
    tick();
    @(negedge clk);
    chk("single_res_t1", spike_resolved, 4'b0100);
    chk("single_valid_t1", pkt_valid, 1'b1);
    tick();
    @(negedge clk);
    chk("single_res_t2", spike_resolved, 4'h0);
    chk("single_valid_t2", pkt_valid, 1'b0);
    spike_detected = '0;
    tick();

    // Simultaneous spikes right after reset
    rst_n = 1'b0;
    tick();
    sb.delete(); ts_m = 16'h0;
    rst_n = 1'b1;
    tick();
    spike_detected = 4'b1011;
    sb.push_back(32'h0000_0000);
    sb.push_back(32'h0000_0001);
    sb.push_back(32'h0000_0003);
    @(negedge clk);
    chk("simul_res_t", spike_resolved, 4'h0);
    tick(); @(negedge clk);
    chk("simul_res_t1", spike_resolved, 4'b0001);
    tick(); @(negedge clk);
    chk("simul_res_t2", spike_resolved, 4'b0010);
    tick(); @(negedge clk);
    chk("simul_res_t3", spike_resolved, 4'b1000);
    tick();
    spike_detected = '0;
    @(negedge clk);
    chk("simul_res_t4", spike_resolved, 4'h0);
    chk("simul_valid_t4", pkt_valid, 1'b0);
    tick();

    // Held flag yields one event
    spike_detected = 4'b0010;
    sb.push_back({ts_m, 8'h00, 8'd1});
    pops0 = pops_n;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) spike_detected = '0;
      @(negedge clk);
      acks += int'(spike_resolved[1]);
      tick();
    end
    chk("held_acks", 32'(acks), 32'd1);
    chk("held_pkts", 32'(pops_n - pops0), 32'd1);

    // Back-pressure: fill the FIFO, ninth spike must wait
    pkt_ready = 1'b0;
    time_step = 1'b1;
    tick();
    for (int e = 0; e < 8; e++) begin
      spike_detected = 4'(1 << (e % 4));
      sb.push_back({ts_m, 8'h00, 8'(e % 4)});
      @(negedge clk);
      if (e == 7) chk("bp_not_full_7", fifo_full, 1'b0);
      tick();
    end
    time_step = 1'b0;
    spike_detected = 4'b0001;
    sb.push_back({ts_m, 8'h00, 8'd0});
    @(negedge clk);
    chk("bp_full", fifo_full, 1'b1);
    chk("bp_res_last", spike_resolved, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      chk("bp_ninth_withheld", spike_resolved, 4'h0);
      chk("bp_still_full", fifo_full, 1'b1);
      chk("bp_head_stable", pkt_data, sb[0]);
    end
    tick();
    pkt_ready = 1'b1;
    @(negedge clk);
    chk("bp_full_during_pop", fifo_full, 1'b1);
    tick();
    pkt_ready = 1'b0;
    @(negedge clk);
    chk("bp_no_push_on_full_pop", spike_resolved, 4'h0);
    chk("bp_one_free", fifo_full, 1'b0);
    tick();
    @(negedge clk);
    chk("bp_ninth_acked", spike_resolved, 4'b0001);
    chk("bp_full_again", fifo_full, 1'b1);
    tick();
    spike_detected = '0;
    drain();

    // Timestamp wrap coincident with a grant
    time_step = 1'b1;
    while (ts_m != 16'hFFFF) tick();
    spike_detected = 4'b0100;
    sb.push_back(32'hFFFF_0002);
    tick();
    time_step = 1'b0;
    spike_detected = '0;
    @(negedge clk);
    chk("wrap_res", spike_resolved, 4'b0100);
    chk("wrap_model_ts", 32'(ts_m), 32'h0);
    tick();
    spike_detected = 4'b1000;
    sb.push_back(32'h0000_0003);
    tick();
    spike_detected = '0;
    drain();

    // Mid-operation reset with three queued events
    pkt_ready = 1'b0;
    spike_detected = 4'b0111;
    tick(); tick(); tick();
    spike_detected = '0;
    @(negedge clk);
    chk("mid_queued_valid", pkt_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", pkt_valid, 1'b0);
    chk("mid_async_full", fifo_full, 1'b0);
    chk("mid_async_data", pkt_data, 32'h0);
    chk("mid_async_res", spike_resolved, 4'h0);
    sb.delete(); ts_m = 16'h0;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_after_valid", pkt_valid, 1'b0);
    chk("mid_after_evt", evt_count, 16'h0);
    tick();

    // Twenty pushes for the event counter
    pkt_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      spike_detected = 4'(1 << (k % 4));
      sb.push_back({ts_m, 8'h00, 8'(k % 4)});
      tick();
    end
    spike_detected = '0;
    drain();
`ifdef SEQ_EVT_COUNT_EN
    evt_exp = 16'd20;
`else
    evt_exp = 16'd0;
`endif
    @(negedge clk);
    chk("evt_count_20", evt_count, evt_exp);
    chk("end_valid", pkt_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
